// File: rtl/mc_in_capture.sv
// Input capture: synchronises and debounces CH input lines, queues activity per line and
// reports the lowest active line as a 1-based channel code framed by an io_catch strobe.
module mc_in_capture #(
  parameter int CH        = 32,
  parameter int CODE_W    = 6,
  parameter int DEB_W     = 16,
  parameter int CATCH_CYC = 4
) (
  input  logic              io_clk,
  input  logic              io_rst,
  input  logic [CH-1:0]     io_inPort,
  input  logic              io_mode,
  input  logic              io_enable,
  input  logic [DEB_W-1:0]  io_debounce,
  input  logic              finish,
  output logic [CODE_W-1:0] ctrl,
  output logic              io_catch,
  output logic              io_busy,
  output logic              io_overrun
);

  localparam int CNT_W = (CATCH_CYC > 1) ? $clog2(CATCH_CYC) : 1;

  typedef enum logic [1:0] {IDLE, CATCH, HOLD} state_t;

  logic [CH-1:0]     sync1_reg, sync2_reg, deb_vec, deb_d_reg, pend_reg;
  logic [CH-1:0]     rise, req, take, take_eff, lost;
  logic              mode_d_reg, mode_chg, any_req, start;
  logic [CODE_W-1:0] sel_code;
  state_t            state_reg;
  logic [CODE_W-1:0] ctrl_reg;
  logic              catch_reg, busy_reg, overrun_reg;
  logic [CNT_W-1:0]  catch_cnt_reg;

  always_ff @(posedge io_clk or negedge io_rst) begin
    if (!io_rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= io_inPort;
      sync2_reg <= sync1_reg;
    end
  end

  // A channel's debounced state flips only after the new value has been seen
  // io_debounce consecutive cycles; any bounce back restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic             deb_reg;
      always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg >= io_debounce) begin
          deb_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else if (cnt_reg != '1) begin
          cnt_reg <= cnt_reg + DEB_W'(1);
        end
      end
      assign deb_vec[gi] = deb_reg;
    end
  endgenerate

  assign rise     = deb_vec & ~deb_d_reg;
  assign mode_chg = (io_mode != mode_d_reg);
  assign req      = mode_chg ? '0 : (io_mode ? deb_vec : pend_reg);

  always_comb begin
    any_req  = 1'b0;
    sel_code = '0;
    take     = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req  = 1'b1;
        sel_code = CODE_W'(i + 1);
        take     = '0;
        take[i]  = 1'b1;
      end
    end
  end

  assign start    = (state_reg == IDLE) && io_enable && any_req;
  assign take_eff = start ? take : '0;
  // An edge is lost if its line is already pending or is being picked up this very cycle.
  assign lost     = (io_mode || mode_chg) ? '0 : (rise & (pend_reg | take_eff));

  always_ff @(posedge io_clk or negedge io_rst) begin
    if (!io_rst) begin
      deb_d_reg     <= '0;
      pend_reg      <= '0;
      mode_d_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      state_reg     <= IDLE;
      ctrl_reg      <= '0;
      catch_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      catch_cnt_reg <= '0;
    end else begin
      deb_d_reg   <= deb_vec;
      mode_d_reg  <= io_mode;
      overrun_reg <= |lost;
      if (mode_chg || io_mode)
        pend_reg <= '0;
      else
        pend_reg <= (pend_reg & ~take_eff) | (rise & ~lost);

      case (state_reg)
        IDLE: begin
          if (start) begin
            ctrl_reg      <= sel_code;
            catch_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            catch_cnt_reg <= CNT_W'(CATCH_CYC - 1);
            state_reg     <= CATCH;
          end
        end
        CATCH: begin
          if (catch_cnt_reg == '0) begin
            catch_reg <= 1'b0;
            state_reg <= HOLD;
          end else begin
            catch_cnt_reg <= catch_cnt_reg - CNT_W'(1);
          end
        end
        HOLD: begin
          if (finish) begin
            ctrl_reg  <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctrl       = ctrl_reg;
  assign io_catch   = catch_reg;
  assign io_busy    = busy_reg;
  assign io_overrun = overrun_reg;

endmodule

// File: tb/tb_mc_in_capture.sv
// Directed bench for mc_in_capture: per-cycle vector table for edge reports and
// hand-written sequences for debounce, overrun, level mode and mid-report reset.
module tb_mc_in_capture;
  localparam int CH = 32, CODE_W = 6, DEB_W = 16, CATCH_CYC = 4;

  logic              io_clk = 1'b0;
  logic              io_rst = 1'b1;
  logic [CH-1:0]     io_inPort = '0;
  logic              io_mode = 1'b0;
  logic              io_enable = 1'b1;
  logic [DEB_W-1:0]  io_debounce = '0;
  logic              finish = 1'b0;
  logic [CODE_W-1:0] ctrl;
  logic              io_catch, io_busy, io_overrun;

  int checks = 0;
  int errors = 0;

  mc_in_capture #(.CH(CH), .CODE_W(CODE_W), .DEB_W(DEB_W), .CATCH_CYC(CATCH_CYC)) dut (
    .io_clk(io_clk), .io_rst(io_rst), .io_inPort(io_inPort), .io_mode(io_mode),
    .io_enable(io_enable), .io_debounce(io_debounce), .finish(finish),
    .ctrl(ctrl), .io_catch(io_catch), .io_busy(io_busy), .io_overrun(io_overrun)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    logic [31:0] in_port;
    logic        fin;
    logic [5:0]  e_ctrl;
    logic        e_catch;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] in_port, input logic fin, input logic [5:0] c,
                     input logic cat, input logic b, input int n);
    vec_t v;
    v.in_port = in_port; v.fin = fin; v.e_ctrl = c; v.e_catch = cat; v.e_busy = b;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input int b);
    io_inPort[b] = 1'b1;
    step();
    io_inPort[b] = 1'b0;
  endtask

  task automatic finish_pulse();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic wait_catch(input string name, input logic lvl, input int budget);
    int n = 0;
    while (io_catch !== lvl && n < budget) begin
      step();
      n++;
    end
    check(name, io_catch, lvl);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset / idle
    #1 io_rst = 1'b0;
    #2;
    check("rst_ctrl", ctrl, 0);
    check("rst_catch", io_catch, 0);
    check("rst_busy", io_busy, 0);
    check("rst_ovr", io_overrun, 0);
    @(negedge io_clk) io_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_catch", io_catch, 0);
      check("idle_busy", io_busy, 0);
    end

    // Single edge on bit 4, then priority/queueing of bits 9 and 2
    add(32'h10,  0, 0, 0, 0, 4);
    add(32'h10,  0, 5, 1, 1, 1);
    add(32'h10,  1, 5, 1, 1, 1);   // finish during CATCH is ignored
    add(32'h10,  0, 5, 1, 1, 2);
    add(32'h10,  0, 5, 0, 1, 2);
    add(32'h10,  1, 0, 0, 0, 1);
    add(32'h0,   0, 0, 0, 0, 3);
    add(32'h204, 0, 0, 0, 0, 4);
    add(32'h204, 0, 3, 1, 1, 4);
    add(32'h204, 0, 3, 0, 1, 1);
    add(32'h204, 1, 0, 0, 0, 1);   // gap cycle after finish
    add(32'h204, 0, 10, 1, 1, 4);
    add(32'h204, 0, 10, 0, 1, 1);
    add(32'h204, 1, 0, 0, 0, 1);
    add(32'h0,   0, 0, 0, 0, 3);
    for (int i = 0; i < tbl.size(); i++) begin
      io_inPort = tbl[i].in_port;
      finish    = tbl[i].fin;
      step();
      $display("row %0d in=%h fin=%0d ctrl=%0d catch=%0d busy=%0d", i, tbl[i].in_port,
               tbl[i].fin, ctrl, io_catch, io_busy);
      check("tbl_ctrl", ctrl, tbl[i].e_ctrl);
      check("tbl_catch", io_catch, tbl[i].e_catch);
      check("tbl_busy", io_busy, tbl[i].e_busy);
      check("tbl_ovr", io_overrun, 0);
    end
    finish = 1'b0;

    // Debounce: bouncing bit 0 never reports, stable high reports after 8+4 cycles
    io_debounce = 16'd8;
    for (int c = 0; c < 40; c++) begin
      io_inPort[0] = ((c / 3) % 2 == 0);
      step();
      check("deb_bounce_catch", io_catch, 0);
    end
    io_inPort[0] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      check("deb_wait_catch", io_catch, 0);
    end
    step();
    check("deb_catch", io_catch, 1);
    check("deb_ctrl", ctrl, 1);
    $display("debounce report ctrl=%0d", ctrl);
    repeat (4) step();
    check("deb_hold_catch", io_catch, 0);
    finish_pulse();
    check("deb_done_ctrl", ctrl, 0);
    io_debounce = '0;
    io_inPort = '0;
    repeat (3) step();

    // Overrun on channel 7
    pulse(7);
    for (int s = 2; s <= 4; s++) begin
      step();
      check("ovr_pre_catch", io_catch, 0);
    end
    step();
    check("ovr_catch", io_catch, 1);
    check("ovr_ctrl", ctrl, 8);
    repeat (4) step();
    check("ovr_hold_catch", io_catch, 0);
    check("ovr_hold_ctrl", ctrl, 8);
    pulse(7);
    check("ovr_rep1_ovr", io_overrun, 0);
    for (int s = 2; s <= 6; s++) begin
      step();
      check("ovr_rep1_ovr", io_overrun, 0);
    end
    pulse(7);
    check("ovr_rep2_ovr_s1", io_overrun, 0);
    step();
    check("ovr_rep2_ovr_s2", io_overrun, 0);
    step();
    check("ovr_rep2_ovr_s3", io_overrun, 0);
    step();
    check("ovr_rep2_ovr_pulse", io_overrun, 1);
    step();
    check("ovr_rep2_ovr_s5", io_overrun, 0);
    check("ovr_rep2_ctrl", ctrl, 8);
    finish_pulse();
    check("ovr_fin_ctrl", ctrl, 0);
    check("ovr_fin_busy", io_busy, 0);
    step();
    check("ovr_again_catch", io_catch, 1);
    check("ovr_again_ctrl", ctrl, 8);
    $display("overrun re-report ctrl=%0d", ctrl);
    repeat (4) step();
    finish_pulse();
    check("ovr_end_ctrl", ctrl, 0);
    for (int s = 0; s < 10; s++) begin
      step();
      check("ovr_no_more_catch", io_catch, 0);
    end

    // Level mode: bit 31 held high is reported again after each finish
    io_mode = 1'b1;
    io_inPort[31] = 1'b1;
    wait_catch("lvl_first_catch", 1'b1, 12);
    check("lvl_first_ctrl", ctrl, 32);
    for (int r = 0; r < 2; r++) begin
      wait_catch("lvl_catch_low", 1'b0, 10);
      finish_pulse();
      check("lvl_gap_ctrl", ctrl, 0);
      check("lvl_gap_catch", io_catch, 0);
      step();
      check("lvl_rerep_catch", io_catch, 1);
      check("lvl_rerep_ctrl", ctrl, 32);
      $display("level re-report %0d ctrl=%0d", r, ctrl);
    end

    // Asynchronous reset during CATCH
    #2 io_rst = 1'b0;
    #1;
    check("arst_catch", io_catch, 0);
    check("arst_ctrl", ctrl, 0);
    check("arst_busy", io_busy, 0);
    io_mode = 1'b0;
    io_inPort = '0;
    @(negedge io_clk) io_rst = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      check("arst_after_catch", io_catch, 0);
      check("arst_after_busy", io_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
